imem_port_arbiter: RTL

//  Shares the single-port synchronous instruction SRAM between CPU fetch (M0) and a program loader/debug master (M1).

---
 rtl/imem_arb_pkg.sv | 19 +
 rtl/imem_arb_starve_cnt.sv | 29 ++
 rtl/imem_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter: FSM states and
// read-response owner tags.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_LOCK = 2'd1,
        ST_BOOT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam int IMEM_DW = 32;

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Saturating count of cycles the loader has been kept waiting; sat tells the
// arbiter the loader must win the next contended cycle.
module imem_arb_starve_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != CW'(MAX_WAIT))) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign sat = (cnt_reg == CW'(MAX_WAIT));

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction SRAM between CPU fetch (M0) and the
// loader (M1). Define IMEM_ARB_BOOT_HOLD_EN to add the post-reset BOOT hold.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int AW       = 12,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          boot_done,
    output logic          cpu_hold
);

    arb_state_t state_reg, state_next;
    owner_t     own_reg, own_next;
    logic       g0, g1;
    logic       sat;
    logic       in_boot, boot_exit;
    logic       m1_wr;

`ifdef IMEM_ARB_BOOT_HOLD_EN
    localparam arb_state_t RESET_STATE = ST_BOOT;
    assign in_boot   = (state_reg == ST_BOOT);
    assign boot_exit = boot_done;
`else
    localparam arb_state_t RESET_STATE = ST_ARB;
    logic boot_done_unused;
    assign boot_done_unused = boot_done;
    assign in_boot   = 1'b0;
    assign boot_exit = 1'b0;
`endif

    assign cpu_hold = in_boot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_STATE;
            own_reg   <= OWN_NONE;
        end else begin
            state_reg <= state_next;
            own_reg   <= own_next;
        end
    end

    // A lock beat without lock/req falls through to normal arbitration in the same cycle.
    always_comb begin
        g0         = 1'b0;
        g1         = 1'b0;
        state_next = state_reg;
        if (in_boot) begin
            g1 = m1_req;
            if (boot_exit) begin
                state_next = ST_ARB;
            end
        end else if ((state_reg == ST_LOCK) && m1_req && m1_lock) begin
            g1 = 1'b1;
        end else begin
            g1         = m1_req & (~m0_req | sat);
            g0         = m0_req & ~g1;
            state_next = (g1 && m1_lock) ? ST_LOCK : ST_ARB;
        end
    end

    // Grants are forced low while reset is held so the SRAM sees no access.
    assign m0_gnt = g0 & rst_n;
    assign m1_gnt = g1 & rst_n;
    assign m1_wr  = m1_gnt & m1_we;

    imem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (m1_req & ~m1_gnt),
        .clr   (m1_gnt | ~m1_req),
        .sat   (sat)
    );

    assign mem_en    = m0_gnt | m1_gnt;
    assign mem_we    = m1_wr;
    assign mem_be    = m1_wr ? m1_be : 4'b0000;
    assign mem_wdata = m1_wr ? m1_wdata : 32'd0;
    assign mem_addr  = m1_gnt ? m1_addr : (m0_gnt ? m0_addr : '0);

    always_comb begin
        own_next = OWN_NONE;
        if (m0_gnt) begin
            own_next = OWN_M0;
        end else if (m1_gnt && !m1_we) begin
            own_next = OWN_M1;
        end
    end

    assign m0_rvalid = (own_reg == OWN_M0);
    assign m1_rvalid = (own_reg == OWN_M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'd0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'd0;

endmodule
